// File: rtl/alu_arbiter.sv
// Two-requester arbiter and sequencer in front of a shared 64-bit ALU.
// Optional macro ALU_ARB_RR_EN selects round-robin contention; default is fixed priority (req0).
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_opcode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic [1:0]  dbg_state,
  output logic        dbg_last_grant
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a requester holds valid and payload stable until it sees ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        last_grant;
  logic        grant;
  logic        contend_pick;
  logic        any_valid;
  logic        can_accept;
  logic        accept;

  logic [63:0] op_a, op_b;
  logic [3:0]  op_code;
  logic        op_id;

  logic [64:0] sum, diff;
  logic [63:0] alu_result;
  logic        alu_carry, alu_overflow, alu_zero;

`ifdef ALU_ARB_RR_EN
  assign contend_pick = ~last_grant;
`else
  assign contend_pick = 1'b0;
`endif

  assign any_valid  = req0_valid | req1_valid;
  assign grant      = (req0_valid && req1_valid) ? contend_pick : req1_valid;
  assign can_accept = (state == IDLE) || ((state == DONE) && rsp_ready);
  assign accept     = can_accept && any_valid;
  assign req0_ready = accept && (grant == 1'b0);
  assign req1_ready = accept && (grant == 1'b1);

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (rsp_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared ALU. SUB carry is the carry-out of a + ~b + 1 (1 means no borrow).
  always_comb begin
    sum          = {1'b0, op_a} + {1'b0, op_b};
    diff         = {1'b0, op_a} + {1'b0, ~op_b} + 65'd1;
    alu_result   = 64'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (op_code)
      4'h0: begin
        alu_result   = sum[63:0];
        alu_carry    = sum[64];
        alu_overflow = (op_a[63] == op_b[63]) && (sum[63] != op_a[63]);
      end
      4'h8: begin
        alu_result   = diff[63:0];
        alu_carry    = diff[64];
        alu_overflow = (op_a[63] != op_b[63]) && (diff[63] != op_a[63]);
      end
      4'h1: alu_result = op_a << op_b[5:0];
      4'h2: alu_result = {63'd0, ($signed(op_a) < $signed(op_b))};
      4'h3: alu_result = {63'd0, (op_a < op_b)};
      4'h4: alu_result = op_a ^ op_b;
      4'h5: alu_result = op_a >> op_b[5:0];
      4'h6: alu_result = op_a | op_b;
      4'h7: alu_result = op_a & op_b;
      4'hD: alu_result = $signed(op_a) >>> op_b[5:0];
      default: alu_result = 64'd0;
    endcase
    alu_zero = (alu_result == 64'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a         <= 64'd0;
      op_b         <= 64'd0;
      op_code      <= 4'd0;
      op_id        <= 1'b0;
      last_grant   <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 64'd0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= grant ? req1_a : req0_a;
        op_b       <= grant ? req1_b : req0_b;
        op_code    <= grant ? req1_opcode : req0_opcode;
        op_id      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= op_id;
        rsp_result   <= alu_result;
        rsp_carry    <= alu_carry;
        rsp_overflow <= alu_overflow;
        rsp_zero     <= alu_zero;
      end else if ((state == DONE) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing and sharing controller for the 64-bit ALU (`alu_64_bit`). It arbitrates between two requesters, each with a valid/ready operand port. It registers the granted operands, drives one ALU instance from those registers, and returns the result and flags on a single valid/ready response port tagged with the requester ID. It sits between the two issue sources (integer pipe and address/branch unit) and the shared ALU datapath.

## Interface
- No parameters; data width is fixed at 64 to match `alu_64_bit`.
- Clock and reset: one clock, `clk`. Reset is `rst`: synchronous, active-high.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0 operation is accepted this cycle.
- `req0_a`, `req0_b` input 64 each: requester 0 operands.
- `req0_opcode` input 4: requester 0 ALU opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_opcode`: same as requester 0, for requester 1.
- `rsp_valid` output 1: response registers hold a completed result.
- `rsp_ready` input 1: downstream consumes the response.
- `rsp_id` output 1: index of the requester that issued the operation.
- `rsp_result` output 64: ALU result.
- `rsp_carry` output 1: ALU `carry_flag`.
- `rsp_overflow` output 1: ALU `overflow_flag`.
- `rsp_zero` output 1: ALU `zero_flag`.

## Operation
- Opcode map, as implemented by the ALU:
  - 0x0 ADD, 0x1 SLL, 0x2 SLT, 0x3 SLTU, 0x4 XOR, 0x5 SRL, 0x6 OR, 0x7 AND, 0x8 SUB, 0xD SRA.
  - Any other opcode yields result 0, carry 0, overflow 0, zero 1.
  - The opcode is passed through unchanged; it is not flagged as an error.
- State machine states are IDLE, EXEC and DONE.
  - IDLE: the granted requester sees ready=1. On a handshake, capture a, b, opcode and the grant ID into the operand registers, then go to EXEC.
  - EXEC: the ALU evaluates the operand registers combinationally. Capture result and flags into the response registers, set `rsp_valid`, and go to DONE. EXEC always lasts exactly 1 cycle.
  - DONE: hold the response stable while `rsp_valid`=1 and `rsp_ready`=0.
    - On the `rsp_ready` handshake, go to IDLE.
    - If a new request is accepted in that same cycle, go straight to EXEC.
- Ready rule: `reqN_ready` = (state==IDLE or (state==DONE and `rsp_ready`)) and grant==N. At most one ready is high per cycle.
- Grant is evaluated combinationally from the two valids:
  - Only one valid: that requester is granted.
  - Both valid: chosen by the arbitration policy (see Configuration).
  - Neither valid: no grant.
- Requester rule: once `reqN_valid` is asserted, it and its operands stay stable until `reqN_ready`. The arbiter does not latch anything without a handshake.
- `last_grant` (1 bit) updates only on an accepted request.
- Reset clears everything:
  - state goes to IDLE;
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_carry`, `rsp_overflow` and `rsp_zero` go to 0;
  - operand registers go to 0;
  - `last_grant` goes to 1, so requester 0 wins the first contention.
- Reset mid-operation (EXEC or DONE) discards the in-flight operation. No response is produced for it.

## Timing
- Latency: a request handshake in cycle N gives `rsp_valid`=1 in cycle N+2.
- Back-to-back throughput with `rsp_ready` held at 1 is one operation per 2 cycles, because the DONE handshake overlaps the next accept.
- Response outputs are register-driven. They have no combinational path from the `req*` inputs.
- `reqN_ready` depends combinationally on `rsp_ready`, the valids and the state.

## Configuration
- Macro: `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration. Under contention, grant goes to the requester other than `last_grant`.
- Undefined: fixed priority. Requester 0 always wins contention, and `last_grant` is still maintained but unused.

## Test plan
- Single ADD:
  - Stimulus: requester 0 sends a=5, b=3, op 0x0.
  - Response: `rsp_valid` appears 2 cycles after acceptance with result=8, id=0, carry=0, overflow=0, zero=0.
- SUB to zero and signed overflow:
  - Stimulus: requester 1 sends SUB 3-3.
  - Response: result=0, zero=1, id=1.
  - Stimulus: then ADD 0x7FFF_FFFF_FFFF_FFFF+1.
  - Response: result=0x8000_0000_0000_0000, overflow=1.
- Contention:
  - Stimulus: both valid continuously for 4 ops, `rsp_ready`=1.
  - Response with `ALU_ARB_RR_EN`: ids 0,1,0,1.
  - Response without it: ids 0,0,0,0.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - Response: outputs are stable and both `reqN_ready` are 0. Release `rsp_ready` while req1 is valid; req1 is accepted in the same cycle and its response follows 2 cycles later.
- Illegal opcode:
  - Stimulus: op 0xF with a=b=all ones.
  - Response: result=0, carry=0, overflow=0, zero=1.
- Reset mid-operation:
  - Stimulus: assert `rst` in EXEC.
  - Response: next cycle `rsp_valid`=0, state is IDLE, and no stale response is ever emitted. The next contention grants requester 0.
